mult_pipe_param: RTL
====================

Name: mult_pipe_param

Overview:
- Parametrised, fully pipelined WIDTH x WIDTH multiplier. Successor to the fixed 8-bit pipelined multiplier.
- Adds a per-transaction signed/unsigned mode, a valid/ready handshake with backpressure, a tag passthrough and a synchronous flush.
- Sits between operand-producing datapath logic and downstream accumulators. Accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept this cycle.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  tag returned with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  2*WIDTH  product.
- out_tag  output  TAG_W  tag of that product.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage registers and valid bits clear.
  - out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 once rst_n is high.
- Pipeline: three register stages, each with its own valid bit.
  - S1 captures in_a, in_b, in_signed and in_tag on acceptance (in_valid && in_ready).
  - S2 holds WIDTH/2 pair sums of partial products: pp[2i] + pp[2i+1], each 2*WIDTH bits, plus signed/tag.
  - S3 is the output register: the sum of all S2 pair sums, truncated to 2*WIDTH bits.
- Latency: operation accepted at edge k is presented on out_data/out_valid after edge k+2, with no stall.
- Throughput: one operation per cycle.
- Stall rule:
  - stall = out_valid && !out_ready.
  - While stalled, every stage holds (global enable = !stall) and in_ready = !stall.
  - Bubbles are not collapsed.
  - in_ready is combinational from out_valid/out_ready only, never from in_valid.
- Result handover: a result is consumed on an edge with out_valid && out_ready. The next result, or 0 with out_valid low, appears after that edge.
- out_data and out_tag are 0 whenever out_valid = 0. Invalid stages must also propagate zero data.
- Arithmetic:
  - Unsigned: exact a*b in 2*WIDTH bits; cannot overflow.
  - Signed: exact two's-complement product in 2*WIDTH bits. Sign handling (Baugh-Wooley or sign-extended partial products) is an implementation choice, but latency is identical for both modes.
  - Edge case: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits and must be exact.
- in_signed is per operation and travels with the data. Mixed modes back-to-back are legal.
- Flush (synchronous):
  - Clears all three valid bits and data on the next edge, regardless of stall.
  - An input presented in the same cycle as flush is dropped.
  - in_ready stays 1 during flush.
- Reset mid-operation: all in-flight operations are discarded. No result appears after reset release until a new operation is accepted.
- Pipeline registers are written only when their stage enable is high. Data registers of invalid stages may be gated for power, but must still satisfy the zero-output rule.

Decomposition:
- Shared package mult_pipe_pkg holds:
  - LATENCY = 3;
  - the product width function prod_w(w) = 2*w;
  - the pair-sum count function pairs(w) = w/2.
- One combinational sub-module mult_pp_pair:
  - inputs: a, b, signed flag, pair index;
  - output: the 2*WIDTH pair sum;
  - instantiated WIDTH/2 times via generate.
- All stage registers, handshake and flush logic stay in the top.

Test Plan:
- Unsigned max, WIDTH=8: a=0xFF, b=0xFF, signed=0, tag=0x3 -> out_data=0xFE01, out_tag=0x3, out_valid after edge k+2.
- Signed corners: (-128)*(-128) -> 0x4000; (-1)*127 -> 0xFF81; 0x80*0x01 with signed=0 -> 0x0080. Issue back-to-back -> results on three consecutive cycles in order.
- Backpressure: stream 5 ops (a=i, b=i+1) with out_ready low for cycles 3-6 -> in_ready low exactly while out_valid && !out_ready. No loss or duplication: products 0, 2, 6, 12, 20 in order.
- Flush: 3 ops in flight, assert flush for one cycle -> out_valid stays 0 afterward; the next accepted op 7*9 returns 0x003F at latency 3.
- Reset mid-stream: pulse rst_n low asynchronously between edges with 2 ops in flight -> outputs 0 immediately, no stale result after release, in_ready = 1.
- WIDTH=16 regression: 1000 random signed/unsigned ops with random out_ready -> scoreboard matches the reference product and tag.

Source files
------------

// File: rtl/mult_pipe_pkg.sv
// rtl/mult_pipe_pkg.sv - shared constants and width helpers for the pipelined multiplier
//
// Purpose : pipeline depth and the width arithmetic used by mult_pipe_param and
//           mult_pp_pair, kept in one place so both files size ports identically.
// Contents: LATENCY    - number of register stages between input and output
//           prod_w     - product width for a w-bit operand
//           pairs      - number of partial-product pairs for a w-bit multiplier
//           pair_idx_w - bits needed to index those pairs (never less than 1)

package mult_pipe_pkg;

  localparam int LATENCY = 3;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  function automatic int pairs(input int w);
    return w / 2;
  endfunction

  function automatic int pair_idx_w(input int w);
    return ((w / 2) > 1) ? $clog2(w / 2) : 1;
  endfunction

endpackage

// File: rtl/mult_pp_pair.sv
// rtl/mult_pp_pair.sv - combinational sum of one adjacent pair of partial products
//
// Purpose : for pair index p, returns pp[2p] + pp[2p+1] in 2*WIDTH bits, where
//           pp[j] is the multiplicand weighted by bit j of the multiplier.
// Ports   : a         in  WIDTH       multiplicand
//           b         in  WIDTH       multiplier
//           is_signed in  1           1 = two's-complement operands
//           pair_idx  in  pair_idx_w  which pair (0 .. WIDTH/2-1)
//           pair_sum  out 2*WIDTH     pp[2p] + pp[2p+1], modulo 2^(2*WIDTH)

module mult_pp_pair
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int PW = prod_w(WIDTH),
  localparam int IW = pair_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic [IW-1:0]    pair_idx,
  output logic [PW-1:0]    pair_sum
);

  // Bit position of the multiplier's sign bit, sized to the bit-index width.
  localparam logic [IW:0] MSB_J = (IW + 1)'(WIDTH - 1);

  logic [PW-1:0] a_ext;
  logic [IW:0]   j_lo;
  logic [IW:0]   j_hi;
  logic [PW-1:0] pp_lo;
  logic [PW-1:0] pp_hi;

  // Sign-extended partial products: the multiplicand is widened to the full
  // product width, and in signed mode the multiplier's top bit carries weight
  // -2^(WIDTH-1), so that one partial product is negated. All arithmetic is
  // modulo 2^(2*WIDTH), which makes the truncated sum exact for both modes.
  always_comb begin
    a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    j_lo  = {pair_idx, 1'b0};
    j_hi  = {pair_idx, 1'b1};
    pp_lo = b[j_lo] ? (a_ext << j_lo) : '0;
    pp_hi = b[j_hi] ? (a_ext << j_hi) : '0;
    if (is_signed && (j_hi == MSB_J)) begin
      pp_hi = '0 - pp_hi;
    end
    pair_sum = pp_lo + pp_hi;
  end

endmodule

// File: rtl/mult_pipe_param.sv
// rtl/mult_pipe_param.sv - parametrised three-stage pipelined multiplier with valid/ready
//
// Purpose : WIDTH x WIDTH multiplier, signed or unsigned per operation, one
//           operation per cycle, result two edges after acceptance. A single
//           global enable stalls all stages while the output is held.
// Ports   : clk        in  1        rising-edge clock
//           rst_n      in  1        asynchronous active-low reset
//           flush      in  1        synchronous clear of everything in flight
//           in_valid   in  1        operands present
//           in_ready   out 1        block can accept this cycle
//           in_signed  in  1        1 = two's-complement operands
//           in_a       in  WIDTH    multiplicand
//           in_b       in  WIDTH    multiplier
//           in_tag     in  TAG_W    tag returned with the result
//           out_valid  out 1        result present
//           out_ready  in  1        consumer accepts the result
//           out_data   out 2*WIDTH  product (0 when out_valid is low)
//           out_tag    out TAG_W    tag of that product (0 when out_valid is low)

module mult_pipe_param
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_w(WIDTH)-1:0] out_data,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int PW = prod_w(WIDTH);
  localparam int NP = pairs(WIDTH);
  localparam int IW = pair_idx_w(WIDTH);

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_signed_q, s1_signed_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Stage 2: pair sums (the sign is already folded into them)
  logic                  s2_valid_q, s2_valid_d;
  logic [NP-1:0][PW-1:0] s2_sum_q, s2_sum_d;
  logic [TAG_W-1:0]      s2_tag_q, s2_tag_d;

  // Stage 3: output register
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic                  stall;
  logic                  en;
  logic                  accept;
  logic [NP-1:0][PW-1:0] pp_sum;
  logic [PW-1:0]         total;

  // Only a held output result can stall; bubbles further up are not squeezed
  // out. in_ready also stays high during flush, although that input is dropped.
  assign stall    = out_valid_q && !out_ready;
  assign en       = !stall;
  assign in_ready = en || flush;
  assign accept   = in_valid && en && !flush;

  for (genvar g = 0; g < NP; g++) begin : g_pair
    mult_pp_pair #(
      .WIDTH (WIDTH)
    ) u_pair (
      .a         (s1_a_q),
      .b         (s1_b_q),
      .is_signed (s1_signed_q),
      .pair_idx  (IW'(g)),
      .pair_sum  (pp_sum[g])
    );
  end

  always_comb begin
    total = '0;
    for (int i = 0; i < NP; i++) begin
      total = total + s2_sum_q[i];
    end
  end

  // Invalid stages carry zero data so the output is zero whenever
  // out_valid is low, with no masking needed at the ports.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_signed_d = s1_signed_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_sum_d    = s2_sum_q;
    s2_tag_d    = s2_tag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      s1_a_d      = '0;
      s1_b_d      = '0;
      s1_signed_d = 1'b0;
      s1_tag_d    = '0;
      s2_valid_d  = 1'b0;
      s2_sum_d    = '0;
      s2_tag_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_tag_d   = '0;
    end else if (en) begin
      s1_valid_d  = accept;
      s1_a_d      = accept ? in_a : '0;
      s1_b_d      = accept ? in_b : '0;
      s1_signed_d = accept ? in_signed : 1'b0;
      s1_tag_d    = accept ? in_tag : '0;

      s2_valid_d  = s1_valid_q;
      s2_sum_d    = s1_valid_q ? pp_sum : '0;
      s2_tag_d    = s1_valid_q ? s1_tag_q : '0;

      out_valid_d = s2_valid_q;
      out_data_d  = s2_valid_q ? total : '0;
      out_tag_d   = s2_valid_q ? s2_tag_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_signed_q <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sum_q    <= '0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_signed_q <= s1_signed_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sum_q    <= s2_sum_d;
      s2_tag_q    <= s2_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule
